// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver with ready/valid output; optional even parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);
  localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD * 16);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
  state_t        state;
  logic          rx_s1, rx_s2;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [3:0]    scnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          drop;
`ifdef UART_RX_PARITY_EN
  logic          perr;
  assign drop = perr;
`else
  assign drop = 1'b0;
`endif
  assign tick = tcnt == TW'(DIV - 1);
  // two-flop synchronizer for the asynchronous line
  always_ff @(posedge clk) begin
    if (!rst_n) {rx_s2, rx_s1} <= 2'b11;
    else {rx_s2, rx_s1} <= {rx_s1, rx};
  end
  // oversample tick divider, realigned to the detected start edge
  always_ff @(posedge clk) begin
    if (!rst_n || (state == IDLE && !rx_s2)) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + 1'b1;
  end
  // frame FSM plus output register with handshake and error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      scnt <= '0;
      bidx <= '0;
      shreg <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      perr <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        IDLE: if (!rx_s2) begin
          state <= START;
          scnt <= '0;
        end
        START: if (tick) begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'd7) begin
            scnt <= '0;
            bidx <= '0;
            state <= rx_s2 ? IDLE : DATA;
          end
        end
        DATA: if (tick) begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'd15) begin
            shreg <= {rx_s2, shreg[7:1]};
            bidx <= bidx + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bidx == 3'd7) state <= PARITY;
`else
            if (bidx == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'd15) begin
            perr <= ^shreg ^ rx_s2;
            parity_err <= ^shreg ^ rx_s2;
            state <= STOP;
          end
        end
`endif
        STOP: if (tick) begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'd15) begin
            if (!rx_s2) begin
              frame_err <= 1'b1;
              state <= BREAK;
            end else begin
              state <= IDLE;
              if (!drop && (!m_valid || m_ready)) begin
                m_data <= shreg;
                m_valid <= 1'b1;
              end else if (!drop) overrun <= 1'b1;
            end
          end
        end
        BREAK: if (rx_s2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter CLK_FREQ_HZ, default 100000000, system clock frequency in Hz.
- REQ-002: Parameter BAUD, default 115200, line bit rate.
- REQ-003: Derived constant DIV = CLK_FREQ_HZ / (BAUD*16), integer division, minimum 1; one oversample tick every DIV clocks.
- REQ-004: clk  input  1  single clock; all logic on rising edge.
- REQ-005: rst_n  input  1  synchronous active-low reset.
- REQ-006: rx  input  1  asynchronous serial line, idle high.
- REQ-007: m_data  output  8  received byte.
- REQ-008: m_valid  output  1  m_data holds an unconsumed byte.
- REQ-009: m_ready  input  1  consumer accepts m_data when m_valid && m_ready.
- REQ-010: frame_err  output  1  one-cycle pulse on a bad stop bit.
- REQ-011: overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
- REQ-012: rx passes a 2-flop synchronizer before any use; all line decisions use the synchronized value.
- REQ-013: Tick counter counts 0..DIV-1 and emits a tick at DIV-1; it is cleared on the IDLE->START transition so sampling aligns to the detected edge.
- REQ-014: States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- REQ-015: IDLE: synchronized rx low -> START.
- REQ-016: START: at 8th tick, rx low -> DATA with bit index 0; rx high -> IDLE, no output (glitch reject).
- REQ-017: DATA: every 16 ticks sample one bit into a shift register, LSB first; after bit 7 -> PARITY if compiled in, else STOP.
- REQ-018: STOP: sample at 16th tick; rx high -> byte complete, -> IDLE same cycle; rx low -> frame_err pulse, byte discarded, -> BREAK.
- REQ-019: BREAK: remain until synchronized rx high, then -> IDLE.
- REQ-020: A completed byte appears on m_data with m_valid high the cycle after the stop-bit sample.
- REQ-021: m_valid and m_data hold stable until the handshake; m_valid clears the cycle after m_valid && m_ready unless a new byte loads in that cycle.
- REQ-022: Byte completes while m_valid && !m_ready: new byte dropped, old kept, overrun pulses one cycle.
- REQ-023: Byte completes in the same cycle as m_valid && m_ready: new byte loads, m_valid stays high, no overrun.
- REQ-024: frame_err and overrun are never high for more than one consecutive cycle per event.

Reset
- REQ-025: While rst_n low at a clock edge: state IDLE, synchronizer flops 1, counters 0, m_data 0x00, m_valid 0, frame_err 0, overrun 0.
- REQ-026: Reset mid-frame aborts the frame with no output; after release, the receiver waits for a fresh falling edge.

Configuration
- REQ-027: Macro UART_RX_PARITY_EN defined: a PARITY state samples one bit after data bit 7; even-parity mismatch discards the byte and pulses output parity_err (1 bit, one cycle); STOP is still checked.
- REQ-028: Macro UART_RX_PARITY_EN undefined: no PARITY state, no parity_err port, 8N1 framing.

Verification (CLK_FREQ_HZ=6400000, BAUD=100000 -> DIV=4, 64 clk/bit)
- REQ-029: Send 0xA5 8N1, m_ready=1 -> m_valid one cycle with m_data=0xA5, no error pulses.
- REQ-030: Low glitch of 20 clk on idle rx -> no m_valid, state back to IDLE, then 0x3C received correctly.
- REQ-031: Send 0x55 with stop bit 0, rx then held low 200 clk -> frame_err single pulse, no m_valid; after rx high, 0x81 received.
- REQ-032: m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11, overrun pulses once; raise m_ready -> 0x11 consumed, m_valid drops.
- REQ-033: Assert rst_n=0 during data bit 3 of 0xFF, release -> no m_valid; next 0x0F received correctly.
- REQ-034: With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no m_valid; with parity bit 1 -> m_data=0x07.
